evt_buffer: RTL and testbench

EVT_BUFFER -- requirements
Module: evt_buffer

---
 rtl/evt_buffer_pkg.sv | 14 +
 rtl/evt_buffer_mem.sv | 25 ++
 rtl/evt_buffer.sv | 122 ++++++++++++
 tb/tb_evt_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/evt_buffer_pkg.sv
// Shared widths for the event path plus a saturating counter helper.
// EVT_BITS_DEF and CNT_BITS live here so the packet assembler sees the same values.
package evt_buffer_pkg;

    localparam int EVT_BITS_DEF   = 32;
    localparam int PKT_BITS       = 128;
    localparam int CNT_BITS       = 32;
    localparam int FIFO_DEPTH_DEF = 16;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == '1) ? v : v + CNT_BITS'(1);
    endfunction

endpackage

// File: rtl/evt_buffer_mem.sv
// Simple dual-port event storage: one synchronous write port, one async read port.
// No reset on the array so it maps onto LUTRAM; read data is valid the cycle after a write.
module evt_buffer_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/evt_buffer.sv
// First-word-fall-through event FIFO with accept/drop counters; 1-cycle push-to-valid latency.
// Full back-pressures upstream, or in drop mode accepts and discards; flush deasserts ready.
module evt_buffer
    import evt_buffer_pkg::*;
#(
    parameter int EVT_BITS = EVT_BITS_DEF,
    parameter int DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [EVT_BITS-1:0]    evt_data_in,
    input  logic                   evt_vld_in,
    output logic                   evt_rdy_out,
    output logic [EVT_BITS-1:0]    evt_data_out,
    output logic                   evt_vld_out,
    input  logic                   evt_rdy_in,
    input  logic                   drop_in,
    input  logic                   flush_in,
    input  logic                   cnt_clr_in,
    output logic [$clog2(DEPTH):0] level_out,
    output logic [CNT_BITS-1:0]    evt_cnt_out,
    output logic [CNT_BITS-1:0]    drop_cnt_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [CNT_BITS-1:0] evt_cnt_q, evt_cnt_d;
    logic [CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;
    logic                live_q;
    logic                full;
    logic                up_xfer;
    logic                push;
    logic                drop_evt;
    logic                pop;

    // live_q keeps ready low during reset and rises on the first edge afterwards
    assign full        = (level_q == FULL_LVL);
    assign evt_rdy_out = live_q && !flush_in && (!full || drop_in);
    assign up_xfer     = evt_vld_in && evt_rdy_out;
    assign push        = up_xfer && !full;
    assign drop_evt    = up_xfer && full;
    assign evt_vld_out = (level_q != '0);
    assign pop         = evt_vld_out && evt_rdy_in;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        evt_cnt_d  = evt_cnt_q;
        drop_cnt_d = drop_cnt_q;

        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        if (cnt_clr_in) begin
            evt_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            if (push) begin
                evt_cnt_d = sat_inc(evt_cnt_q);
            end
            if (drop_evt) begin
                drop_cnt_d = sat_inc(drop_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            evt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            live_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            evt_cnt_q  <= evt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            live_q     <= 1'b1;
        end
    end

    evt_buffer_mem #(
        .WIDTH (EVT_BITS),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (evt_data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (evt_data_out)
    );

    assign level_out    = level_q;
    assign evt_cnt_out  = evt_cnt_q;
    assign drop_cnt_out = drop_cnt_q;

endmodule

// File: tb/tb_evt_buffer.sv
// Bench for evt_buffer: directed table, scenario sequences and a queue-based random reference.
module tb_evt_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] evt_data_in = '0;
    logic        evt_vld_in = 1'b0;
    logic        evt_rdy_out;
    logic [31:0] evt_data_out;
    logic        evt_vld_out;
    logic        evt_rdy_in = 1'b0;
    logic        drop_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        cnt_clr_in = 1'b0;
    logic [4:0]  level_out;
    logic [31:0] evt_cnt_out;
    logic [31:0] drop_cnt_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_q[$];
    logic [31:0] m_evt = '0;
    logic [31:0] m_drop = '0;
    logic        m_live = 1'b0;

    evt_buffer #(.EVT_BITS(32), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .evt_data_in  (evt_data_in),
        .evt_vld_in   (evt_vld_in),
        .evt_rdy_out  (evt_rdy_out),
        .evt_data_out (evt_data_out),
        .evt_vld_out  (evt_vld_out),
        .evt_rdy_in   (evt_rdy_in),
        .drop_in      (drop_in),
        .flush_in     (flush_in),
        .cnt_clr_in   (cnt_clr_in),
        .level_out    (level_out),
        .evt_cnt_out  (evt_cnt_out),
        .drop_cnt_out (drop_cnt_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r,
                         input logic dr, input logic fl, input logic cl);
        evt_vld_in  = v;
        evt_data_in = d;
        evt_rdy_in  = r;
        drop_in     = dr;
        flush_in    = fl;
        cnt_clr_in  = cl;
    endtask

    // One clock through the reference: called just after a negedge, returns after the next one.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r,
                         input logic dr, input logic fl, input logic cl);
        logic exp_rdy, push, dropev, pop;
        drive(v, d, r, dr, fl, cl);
        #1;
        exp_rdy = m_live && !fl && (m_q.size() < DEPTH || dr);
        check("rdy_out", evt_rdy_out, exp_rdy);
        check("vld_out", evt_vld_out, m_q.size() != 0);
        if (m_q.size() != 0) check("data_out", evt_data_out, m_q[0]);
        push   = v && exp_rdy && (m_q.size() < DEPTH);
        dropev = v && exp_rdy && (m_q.size() == DEPTH);
        pop    = (m_q.size() != 0) && r;
        if (fl) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(d);
        end
        if (cl) begin
            m_evt  = '0;
            m_drop = '0;
        end else begin
            if (push && m_evt != 32'hFFFF_FFFF) m_evt++;
            if (dropev && m_drop != 32'hFFFF_FFFF) m_drop++;
        end
        @(posedge clk);
        m_live = 1'b1;
        @(negedge clk);
        check("level", 32'(level_out), 32'(m_q.size()));
        check("evt_cnt", evt_cnt_out, m_evt);
        check("drop_cnt", drop_cnt_out, m_drop);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_vld", evt_vld_out, 1'b0);
        check("rst_rdy", evt_rdy_out, 1'b0);
        check("rst_level", 32'(level_out), 0);
        check("rst_evt", evt_cnt_out, 0);
        check("rst_drop", drop_cnt_out, 0);
        m_q.delete();
        m_evt  = '0;
        m_drop = '0;
        m_live = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rdy_before_first_edge", evt_rdy_out, 1'b0);
        @(posedge clk);
        m_live = 1'b1;
        @(negedge clk);
        check("rdy_after_first_edge", evt_rdy_out, 1'b1);
    endtask

    typedef struct {
        logic        vld;
        logic [31:0] dat;
        logic        rdy_in;
        logic        drop;
        logic        flush;
        logic        clr;
        logic        exp_rdy;
        logic        exp_vld;
        logic [31:0] exp_dat;
        logic [4:0]  exp_lvl;
        logic [31:0] exp_evt;
        logic [31:0] exp_drop;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] ev_s, dr_s;
        logic        dr_mode;

        //          vld  dat           rdy dr fl cl | rdy vld dat           lvl evt drop
        vecs[0] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 5'd1, 32'd1, 32'd0};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         5'd0, 32'd1, 32'd0};
        vecs[2] = '{1'b1, 32'hA1,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA1,        5'd1, 32'd0, 32'd0};
        vecs[3] = '{1'b1, 32'hA2,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA1,        5'd2, 32'd1, 32'd0};
        vecs[4] = '{1'b1, 32'hA3,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA2,        5'd2, 32'd2, 32'd0};
        vecs[5] = '{1'b1, 32'hA4,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         5'd0, 32'd2, 32'd0};
        vecs[6] = '{1'b1, 32'hA5,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5,        5'd1, 32'd3, 32'd0};
        vecs[7] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         5'd0, 32'd0, 32'd0};

        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].dat, vecs[i].rdy_in, vecs[i].drop, vecs[i].flush, vecs[i].clr);
            #1;
            check($sformatf("tbl%0d_rdy", i), evt_rdy_out, vecs[i].exp_rdy);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl%0d_vld", i), evt_vld_out, vecs[i].exp_vld);
            if (vecs[i].exp_vld) check($sformatf("tbl%0d_dat", i), evt_data_out, vecs[i].exp_dat);
            check($sformatf("tbl%0d_lvl", i), 32'(level_out), 32'(vecs[i].exp_lvl));
            check($sformatf("tbl%0d_evt", i), evt_cnt_out, vecs[i].exp_evt);
            check($sformatf("tbl%0d_drop", i), drop_cnt_out, vecs[i].exp_drop);
        end

        // Back-pressure: 20 offered, 16 taken, ready stays low, then ordered drain.
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'd99, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("bp_rdy_low", evt_rdy_out, 1'b0);
        check("bp_level", 32'(level_out), 16);
        check("bp_evt", evt_cnt_out, 16);
        check("bp_drop", drop_cnt_out, 0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            check("bp_drain", evt_data_out, 32'(i));
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("bp_empty", evt_vld_out, 1'b0);

        // Drop mode: 20 offered, ready stays high, 4 dropped.
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        check("dm_level", 32'(level_out), 16);
        check("dm_drop", drop_cnt_out, 4);
        check("dm_evt", evt_cnt_out, 16);
        for (int i = 0; i < 16; i++) begin
            check("dm_drain", evt_data_out, 32'h100 + 32'(i));
            cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // Steady push+pop at level 8 for 100 cycles, pointers wrap ~6 times.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 32'h300 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            check("steady_level", 32'(level_out), 8);
        end
        check("steady_evt", evt_cnt_out, 108);

        // Flush at level 10, then clear together with a push.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        ev_s = evt_cnt_out;
        dr_s = drop_cnt_out;
        cycle(1'b1, 32'h4FF, 1'b1, 1'b0, 1'b1, 1'b0);
        check("flush_level", 32'(level_out), 0);
        check("flush_vld", evt_vld_out, 1'b0);
        check("flush_evt_kept", evt_cnt_out, 10);
        check("flush_evt_same", evt_cnt_out, ev_s);
        check("flush_drop_same", drop_cnt_out, dr_s);
        cycle(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_evt", evt_cnt_out, 0);
        check("clr_drop", drop_cnt_out, 0);
        check("clr_push_level", 32'(level_out), 1);

        // Asynchronous reset mid-transfer at level 5.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h6FF, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_vld", evt_vld_out, 1'b0);
        check("arst_rdy", evt_rdy_out, 1'b0);
        check("arst_level", 32'(level_out), 0);
        check("arst_evt", evt_cnt_out, 0);
        do_reset();
        cycle(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_first", evt_data_out, 32'h1);
        check("post_rst_vld", evt_vld_out, 1'b1);

        // Random traffic against the queue reference.
        do_reset();
        dr_mode = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) dr_mode = ($urandom_range(0, 1) == 1);
            cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 4, dr_mode,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
